// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, light codes and default phase durations
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam int GREEN_S_DEF  = 5;
  localparam int YELLOW_S_DEF = 2;
  localparam int ALLRED_S_DEF = 1;
  localparam int PED_S_DEF    = 4;
  localparam int CNT_W_DEF    = 6;
endpackage

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: tick/request inputs and lamp/display outputs of the controller
interface traffic_phase_controller_if #(parameter int CNT_W = 6);
  logic             tick;
  logic             ped_req;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic             walk;
  logic             ped_pending;
  logic [CNT_W-1:0] secs_left;
  logic [2:0]       phase;
  modport master (output tick, ped_req, input ns_light, ew_light, walk, ped_pending, secs_left, phase);
  modport slave  (input tick, ped_req, output ns_light, ew_light, walk, ped_pending, secs_left, phase);
endinterface

// File: rtl/tick_countdown.sv
// tick_countdown: loadable down-counter that steps once per tick and saturates at zero
module tick_countdown #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);
  assign expire = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (tick && !expire) count <= count - 1'b1;
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: tick-timed NS/EW light sequencer with latched pedestrian walk phase
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_S  = GREEN_S_DEF,
  parameter int YELLOW_S = YELLOW_S_DEF,
  parameter int ALLRED_S = ALLRED_S_DEF,
  parameter int PED_S    = PED_S_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  traffic_phase_controller_if.slave bus
);
  phase_t           state_q, nxt;
  logic             adv, load, expire, ped_q, walk_q;
  logic [CNT_W-1:0] count, load_val;
  logic [2:0]       ns_q, ew_q, ns_d, ew_d;

  function automatic logic [CNT_W-1:0] dur(phase_t s);
    return (s == NS_GREEN  || s == EW_GREEN)  ? CNT_W'(GREEN_S - 1)  :
           (s == NS_YELLOW || s == EW_YELLOW) ? CNT_W'(YELLOW_S - 1) :
           (s == PED_WALK)                    ? CNT_W'(PED_S - 1)    : CNT_W'(ALLRED_S - 1);
  endfunction

  tick_countdown #(.W(CNT_W), .RST_VAL(CNT_W'(ALLRED_S - 1))) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .tick(bus.tick), .count(count), .expire(expire)
  );

  always_comb begin
    adv  = bus.tick && expire;
    nxt  = state_q;
    load = adv;
    case (state_q)
      NS_GREEN:  nxt = adv ? NS_YELLOW : NS_GREEN;
      NS_YELLOW: nxt = adv ? ALLRED_1  : NS_YELLOW;
      ALLRED_1:  nxt = adv ? EW_GREEN  : ALLRED_1;
      EW_GREEN:  nxt = adv ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: nxt = adv ? ALLRED_2  : EW_YELLOW;
      ALLRED_2:  nxt = adv ? (ped_q ? PED_WALK : NS_GREEN) : ALLRED_2;
      PED_WALK:  nxt = adv ? NS_GREEN  : PED_WALK;
      default: begin
        nxt  = ALLRED_2;
        load = 1'b1;
      end
    endcase
    load_val = dur(nxt);
    ns_d = (nxt == NS_GREEN) ? GRN : (nxt == NS_YELLOW) ? YEL : RED;
    ew_d = (nxt == EW_GREEN) ? GRN : (nxt == EW_YELLOW) ? YEL : RED;
  end

  // lamps are registered from next-state so they change on the same edge as the phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ALLRED_2;
      ns_q    <= RED;
      ew_q    <= RED;
      walk_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= nxt;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= nxt == PED_WALK;
      ped_q   <= bus.ped_req | (ped_q & ~(adv && state_q == ALLRED_2));
    end

  assign bus.ns_light    = ns_q;
  assign bus.ew_light    = ew_q;
  assign bus.walk        = walk_q;
  assign bus.ped_pending = ped_q;
  assign bus.secs_left   = count;
  assign bus.phase       = state_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed checks of phase sequencing, ped latch, tick hold and reset
module tb_traffic_phase_controller;
  import traffic_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  traffic_phase_controller_if #(.CNT_W(6)) i1 ();
  traffic_phase_controller_if #(.CNT_W(6)) i2 ();

  traffic_phase_controller u_dut (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  traffic_phase_controller #(.GREEN_S(1), .YELLOW_S(1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t1, input logic t2, input logic pr);
    i1.tick = t1;
    i2.tick = t2;
    i1.ped_req = pr;
    @(negedge clk);
    chk("safe1", 32'(i1.ns_light == RED || i1.ew_light == RED), 1);
    chk("safe2", 32'(i2.ns_light == RED || i2.ew_light == RED), 1);
  endtask

  task automatic tk(input int n, input logic fast = 1'b0);
    repeat (n) begin
      cyc(!fast, fast, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic expect1(input string tag, input logic [2:0] ph, input int secs,
                         input logic [2:0] ns, input logic [2:0] ew, input logic wk, input logic pend);
    chk({tag, ".phase"}, 32'(i1.phase), 32'(ph));
    chk({tag, ".secs"}, 32'(i1.secs_left), 32'(secs));
    chk({tag, ".ns"}, 32'(i1.ns_light), 32'(ns));
    chk({tag, ".ew"}, 32'(i1.ew_light), 32'(ew));
    chk({tag, ".walk"}, 32'(i1.walk), 32'(wk));
    chk({tag, ".pend"}, 32'(i1.ped_pending), 32'(pend));
  endtask

  initial begin
    logic [2:0] fast_seq [7];
    fast_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    i1.tick = 1'b0; i2.tick = 1'b0; i1.ped_req = 1'b0; i2.ped_req = 1'b0;
    repeat (2) @(negedge clk);
    expect1("rst", 3'd5, 0, RED, RED, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    expect1("idle", 3'd5, 0, RED, RED, 0, 0);
    // normal loop without pedestrian
    tk(1);  expect1("ng", 3'd0, 4, GRN, RED, 0, 0);
    tk(5);  expect1("ny", 3'd1, 1, YEL, RED, 0, 0);
    tk(2);  expect1("a1", 3'd2, 0, RED, RED, 0, 0);
    tk(1);  expect1("eg", 3'd3, 4, RED, GRN, 0, 0);
    // pedestrian pulse during EW_GREEN
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    expect1("pedlatch", 3'd3, 4, RED, GRN, 0, 1);
    tk(5);  expect1("ey", 3'd4, 1, RED, YEL, 0, 1);
    tk(2);  expect1("a2", 3'd5, 0, RED, RED, 0, 1);
    tk(1);  expect1("walk", 3'd6, 3, RED, RED, 1, 0);
    tk(3);  expect1("walkend", 3'd6, 0, RED, RED, 1, 0);
    tk(1);  expect1("ng2", 3'd0, 4, GRN, RED, 0, 0);
    // tick held low holds everything
    repeat (100) cyc(0, 0, 0);
    expect1("hold", 3'd0, 4, GRN, RED, 0, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    expect1("b2b", 3'd0, 1, GRN, RED, 0, 0);
    tk(2);  expect1("ny2", 3'd1, 1, YEL, RED, 0, 0);
    // request arriving on the very edge that enters PED_WALK
    cyc(0, 0, 1);
    tk(2);  tk(1);  tk(5);  tk(2);
    expect1("a2b", 3'd5, 0, RED, RED, 0, 1);
    cyc(1, 0, 1);
    expect1("walk2", 3'd6, 3, RED, RED, 1, 1);
    tk(4);  expect1("ng3", 3'd0, 4, GRN, RED, 0, 1);
    tk(16); expect1("walk3", 3'd6, 3, RED, RED, 1, 0);
    tk(4);  expect1("ng4", 3'd0, 4, GRN, RED, 0, 0);
    // asynchronous reset in the middle of EW_YELLOW
    tk(5); tk(2); tk(1); tk(5);
    cyc(0, 0, 1);
    expect1("ey2", 3'd4, 1, RED, YEL, 0, 1);
    #2 rst_n = 1'b0;
    #1 expect1("arst", 3'd5, 0, RED, RED, 0, 0);
    @(negedge clk);
    expect1("arst2", 3'd5, 0, RED, RED, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    tk(1);  expect1("restart", 3'd0, 4, GRN, RED, 0, 0);
    // one-tick green/yellow instance
    chk("fast.rst", 32'(i2.phase), 32'd5);
    for (int k = 0; k < 7; k++) begin
      tk(1, 1'b1);
      chk($sformatf("fast.ph%0d", k), 32'(i2.phase), 32'(fast_seq[k]));
      chk($sformatf("fast.secs%0d", k), 32'(i2.secs_left), 0);
    end
    chk("fast.ns", 32'(i2.ns_light), 32'(GRN));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
